// File: rtl/alu_req_arbiter.sv
// Round-robin arbiter sharing one external combinational ALU between N_REQ requesters.
// Define ALU_ARB_FIXED_PRI_EN to replace round-robin with fixed lowest-index-wins priority.
module alu_req_arbiter #(
  parameter int N_REQ = 4,
  parameter int W     = 12
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N_REQ-1:0]     req,
  input  logic [4*N_REQ-1:0]   req_sel,
  input  logic [W*N_REQ-1:0]   req_a,
  input  logic [W*N_REQ-1:0]   req_b,
  output logic [N_REQ-1:0]     gnt,
  output logic [3:0]           alu_sel,
  output logic [W-1:0]         alu_a,
  output logic [W-1:0]         alu_b,
  input  logic [W-1:0]         alu_result,
  input  logic                 alu_agrtb,
  input  logic                 alu_altb,
  input  logic                 alu_aeqb,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [1:0]           rsp_id,
  output logic [W-1:0]         rsp_result,
  output logic                 rsp_agrtb,
  output logic                 rsp_altb,
  output logic                 rsp_aeqb,
  output logic                 busy
);

  typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, RESP = 2'd2} state_t;

  localparam logic [3:0] OP_NOP   = 4'b1111;
  localparam logic [1:0] LAST_IDX = 2'(N_REQ - 1);

  state_t state, state_nxt;

  logic                found;
  logic [1:0]          win_id;
  logic [1:0]          start_idx;
  logic [3:0]          win_sel;
  logic signed [W-1:0] win_a;
  logic signed [W-1:0] win_b;
  logic                accept;
  logic                capture;
  logic                release_rsp;

  logic [3:0]          sel_p0;
  logic signed [W-1:0] a_p0;
  logic signed [W-1:0] b_p0;
  logic [1:0]          owner_p0;

  logic [1:0]          id_p1;
  logic signed [W-1:0] result_p1;
  logic [2:0]          flags_p1;

`ifdef ALU_ARB_FIXED_PRI_EN
  assign start_idx = 2'd0;
`else
  logic [1:0] ptr;
  assign start_idx = ptr;
`endif

  // Winner search: walk N_REQ slots starting at start_idx, wrapping at LAST_IDX.
  always_comb begin
    logic [1:0] idx;
    idx    = start_idx;
    found  = 1'b0;
    win_id = 2'd0;
    for (int k = 0; k < N_REQ; k++) begin
      for (int j = 0; j < N_REQ; j++) begin
        if (!found && (2'(j) == idx) && req[j]) begin
          found  = 1'b1;
          win_id = idx;
        end
      end
      idx = (idx == LAST_IDX) ? 2'd0 : idx + 2'd1;
    end
  end

  always_comb begin
    win_sel = '0;
    win_a   = '0;
    win_b   = '0;
    for (int j = 0; j < N_REQ; j++) begin
      if (2'(j) == win_id) begin
        win_sel = req_sel[4*j +: 4];
        win_a   = req_a[W*j +: W];
        win_b   = req_b[W*j +: W];
      end
    end
  end

  assign accept      = (state == IDLE) && found;
  assign capture     = (state == EXEC);
  assign release_rsp = (state == RESP) && rsp_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (found) state_nxt = EXEC;
      EXEC:    state_nxt = RESP;
      RESP:    if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Grant is also masked by reset so nothing is offered while rst_n is held low.
  always_comb begin
    gnt = '0;
    if ((state == IDLE) && rst_n) begin
      for (int j = 0; j < N_REQ; j++) begin
        gnt[j] = found && (win_id == 2'(j));
      end
    end
    busy      = (state != IDLE);
    rsp_valid = (state == RESP);
  end

`ifndef ALU_ARB_FIXED_PRI_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= 2'd0;
    end else if (release_rsp) begin
      ptr <= (owner_p0 == LAST_IDX) ? 2'd0 : owner_p0 + 2'd1;
    end
  end
`endif

  // Stage p0: operands of the accepted request, held for the ALU through EXEC and RESP.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_p0   <= '0;
      a_p0     <= '0;
      b_p0     <= '0;
      owner_p0 <= '0;
    end else if (accept) begin
      sel_p0   <= win_sel;
      a_p0     <= win_a;
      b_p0     <= win_b;
      owner_p0 <= win_id;
    end
  end

  // Stage p1: response register; a no-op only refreshes the owner id.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      id_p1     <= '0;
      result_p1 <= '0;
      flags_p1  <= '0;
    end else if (capture) begin
      id_p1 <= owner_p0;
      if (sel_p0 != OP_NOP) begin
        result_p1 <= alu_result;
        flags_p1  <= {alu_agrtb, alu_altb, alu_aeqb};
      end
    end
  end

  assign alu_sel    = sel_p0;
  assign alu_a      = a_p0;
  assign alu_b      = b_p0;
  assign rsp_id     = id_p1;
  assign rsp_result = result_p1;
  assign rsp_agrtb  = flags_p1[2];
  assign rsp_altb   = flags_p1[1];
  assign rsp_aeqb   = flags_p1[0];

endmodule

// File: tb/tb_alu_req_arbiter.sv
// Directed bench for alu_req_arbiter with a small behavioural ALU attached.
module tb_alu_req_arbiter;

  localparam int N = 4;
  localparam int W = 12;

  logic             clk;
  logic             rst_n;
  logic [N-1:0]     req;
  logic [4*N-1:0]   req_sel;
  logic [W*N-1:0]   req_a;
  logic [W*N-1:0]   req_b;
  logic [N-1:0]     gnt;
  logic [3:0]       alu_sel;
  logic [W-1:0]     alu_a;
  logic [W-1:0]     alu_b;
  logic [W-1:0]     alu_result;
  logic             alu_agrtb, alu_altb, alu_aeqb;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [1:0]       rsp_id;
  logic [W-1:0]     rsp_result;
  logic             rsp_agrtb, rsp_altb, rsp_aeqb;
  logic             busy;

  int errors = 0;
  int checks = 0;

  alu_req_arbiter #(.N_REQ(N), .W(W)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_sel(req_sel), .req_a(req_a), .req_b(req_b),
    .gnt(gnt), .alu_sel(alu_sel), .alu_a(alu_a), .alu_b(alu_b),
    .alu_result(alu_result), .alu_agrtb(alu_agrtb), .alu_altb(alu_altb), .alu_aeqb(alu_aeqb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_result(rsp_result),
    .rsp_agrtb(rsp_agrtb), .rsp_altb(rsp_altb), .rsp_aeqb(rsp_aeqb), .busy(busy)
  );

  // Behavioural ALU: 0 and, 1 or, 4 add, 5 sub, anything else xor.
  always_comb begin
    case (alu_sel)
      4'b0000: alu_result = alu_a & alu_b;
      4'b0001: alu_result = alu_a | alu_b;
      4'b0100: alu_result = alu_a + alu_b;
      4'b0101: alu_result = alu_a - alu_b;
      default: alu_result = alu_a ^ alu_b;
    endcase
    alu_agrtb = $signed(alu_a) >  $signed(alu_b);
    alu_altb  = $signed(alu_a) <  $signed(alu_b);
    alu_aeqb  = $signed(alu_a) == $signed(alu_b);
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  typedef struct {
    int         id;
    logic [3:0] sel;
    logic [11:0] a;
    logic [11:0] b;
    logic [11:0] res;
    logic [2:0] flg;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 20; i++) begin
      if (!busy) break;
      step();
    end
    check("wait_idle", busy, 0);
  endtask

  function automatic logic [2:0] rsp_flags();
    return {rsp_agrtb, rsp_altb, rsp_aeqb};
  endfunction

  task automatic run_vec(input vec_t v, input int n);
    string tag;
    tag = $sformatf("vec%0d", n);
    req_sel[4*v.id +: 4] = v.sel;
    req_a[W*v.id +: W]   = v.a;
    req_b[W*v.id +: W]   = v.b;
    req = 4'(1 << v.id);
    #1;
    check({tag, "_gnt"}, gnt, 32'(1 << v.id));
    step();
    req = '0;
    check({tag, "_busy"}, busy, 1);
    check({tag, "_early_valid"}, rsp_valid, 0);
    check({tag, "_alu_regs"}, {alu_sel, alu_a, alu_b}, {v.sel, v.a, v.b});
    step();
    check({tag, "_valid"}, rsp_valid, 1);
    check({tag, "_id"}, rsp_id, 32'(v.id));
    check({tag, "_result"}, rsp_result, v.res);
    check({tag, "_flags"}, rsp_flags(), v.flg);
    step();
    check({tag, "_idle"}, busy, 0);
  endtask

  vec_t       vecs[9];
  logic [3:0] g_val[8];
  int         g_cyc[8];
  int         n;
  logic [3:0] exp_g;

  initial begin
    vecs[0] = '{2, 4'b0100, 12'h005, 12'h007, 12'h00C, 3'b010};
    vecs[1] = '{0, 4'b0101, 12'h009, 12'h003, 12'h006, 3'b100};
    vecs[2] = '{1, 4'b0100, 12'hFFF, 12'h001, 12'h000, 3'b010};
    vecs[3] = '{3, 4'b0101, 12'h800, 12'h001, 12'h7FF, 3'b010};
    vecs[4] = '{0, 4'b0000, 12'hF0F, 12'h0FF, 12'h00F, 3'b010};
    vecs[5] = '{1, 4'b0001, 12'h0A0, 12'h0A0, 12'h0A0, 3'b001};
    vecs[6] = '{2, 4'b1111, 12'h000, 12'h000, 12'h0A0, 3'b001};
    vecs[7] = '{3, 4'b0101, 12'h009, 12'h003, 12'h006, 3'b100};
    vecs[8] = '{0, 4'b1111, 12'h000, 12'h000, 12'h006, 3'b100};
    for (int i = 0; i < 8; i++) begin
      g_val[i] = '0;
      g_cyc[i] = 0;
    end

    rst_n     = 1'b0;
    req       = 4'b1111;
    req_sel   = '0;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = 1'b1;
    repeat (3) step();

    check("rst_gnt", gnt, 0);
    check("rst_valid", rsp_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_alu", {alu_sel, alu_a, alu_b}, 0);
    check("rst_rsp", {rsp_id, rsp_result, rsp_flags()}, 0);

    rst_n = 1'b1;
    #1;
    check("gnt_after_rst", gnt, 4'b0001);

    // Round-robin with all requesters held.
    n = 0;
    for (int c = 0; c < 15; c++) begin
      if (c > 0) step();
      if (gnt != '0 && n < 8) begin
        g_val[n] = gnt;
        g_cyc[n] = c;
        n++;
      end
    end
    req = '0;
    check("rr_count", n, 5);
    for (int i = 0; i < 5; i++) begin
`ifdef ALU_ARB_FIXED_PRI_EN
      exp_g = 4'b0001;
`else
      exp_g = 4'(1 << (i % 4));
`endif
      check($sformatf("rr_gnt%0d", i), g_val[i], exp_g);
      check($sformatf("rr_cyc%0d", i), g_cyc[i], 3 * i);
    end
    wait_idle();

    @(negedge clk);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    #1;

    // Back-pressure: requesters 0 and 1, consumer stalled.
    req_sel[3:0] = 4'b0100;
    req_a[11:0]  = 12'd100;
    req_b[11:0]  = 12'hF9C;
    rsp_ready    = 1'b0;
    req          = 4'b0011;
    #1;
    check("bp_gnt0", gnt, 4'b0001);
    step();
    step();
    check("bp_valid", rsp_valid, 1);
    check("bp_rsp", {rsp_id, rsp_result, rsp_flags()}, {2'd0, 12'h000, 3'b100});
    for (int c = 0; c < 10; c++) begin
      step();
      check($sformatf("bp_hold%0d", c),
            {gnt, rsp_valid, rsp_id, rsp_result, rsp_flags()},
            {4'b0000, 1'b1, 2'd0, 12'h000, 3'b100});
    end
    rsp_ready = 1'b1;
    step();
`ifdef ALU_ARB_FIXED_PRI_EN
    check("bp_next_gnt", gnt, 4'b0001);
`else
    check("bp_next_gnt", gnt, 4'b0010);
`endif
    req = '0;
    wait_idle();

    for (int i = 0; i < 9; i++) begin
      run_vec(vecs[i], i);
    end

    // Mid-operation reset in EXEC on requester 2.
    req_sel[11:8] = 4'b0100;
    req_a[35:24]  = 12'd5;
    req_b[35:24]  = 12'd7;
    req           = 4'b0100;
    #1;
    step();
    check("midrst_exec", busy, 1);
    req   = '0;
    rst_n = 1'b0;
    #1;
    check("midrst_busy", busy, 0);
    check("midrst_valid", rsp_valid, 0);
    repeat (2) step();
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      step();
      check($sformatf("midrst_novalid%0d", c), rsp_valid, 0);
    end
    req = 4'b1111;
    #1;
    check("midrst_ptr0", gnt, 4'b0001);
    req = '0;
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu_req_arbiter.md
# alu_req_arbiter

Shares one combinational 12-bit signed ALU (4-bit `sel` opcode, `agrtb`/`altb`/`aeqb` compare flags) between up to four requesters. Each requester presents an opcode and two operands. The block:
- picks one requester round-robin,
- drives the ALU from registered operands,
- captures the result and flags into a response register,
- holds the response until the consumer accepts it.

The block sits between the requesting sequencers and the ALU instance; the ALU itself stays outside this block.

## Interface
- `N_REQ`, 4, number of requesters (2..4); `rsp_id` is 2 bits wide.
- `W`, 12, operand/result width; must match the ALU.

- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `req`  in  N_REQ  per-requester request level.
- `req_sel`  in  4*N_REQ  opcodes; requester i uses bits [4i+3:4i].
- `req_a`  in  W*N_REQ  operand a; requester i uses bits [Wi+W-1:Wi].
- `req_b`  in  W*N_REQ  operand b; same packing as `req_a`.
- `gnt`  out  N_REQ  one-hot grant, combinational, IDLE only.
- `alu_sel`  out  4  registered opcode to the ALU.
- `alu_a`, `alu_b`  out  W  registered operands to the ALU.
- `alu_result`  in  W  ALU result.
- `alu_agrtb`, `alu_altb`, `alu_aeqb`  in  1  ALU compare flags.
- `rsp_valid`  out  1  response available.
- `rsp_ready`  in  1  consumer accepts the response.
- `rsp_id`  out  2  index of the requester that owns the response.
- `rsp_result`  out  W  captured result.
- `rsp_agrtb`, `rsp_altb`, `rsp_aeqb`  out  1  captured flags.
- `busy`  out  1  high whenever state != IDLE.

## Operation
- FSM states and transitions:
  - IDLE: if any `req`, grant the winner. At the edge where `req[i] & gnt[i]`, load `alu_sel`/`alu_a`/`alu_b` from requester i and latch i as owner → EXEC. No `req` → stay in IDLE.
  - EXEC: ALU settles on registered operands; at the next edge, capture result and flags → RESP.
  - RESP: `rsp_valid`=1. When `rsp_valid & rsp_ready`, update the priority pointer → IDLE.
- Winner selection (round-robin): search starts at index `ptr`, wrapping modulo N_REQ. After each completed response, `ptr` = owner+1 (mod N_REQ). A requester that was just served therefore has lowest priority next time.
- `gnt` is zero outside IDLE and zero when no `req` is high. At most one bit is set.
- Requesters hold `req`, `req_sel`, `req_a` and `req_b` stable until granted. A `req` dropped before its grant simply cancels that request. `req` activity during EXEC or RESP is ignored.
- Opcode 4'b1111 (no-op): `rsp_result` and all three `rsp_*` flags keep their previous values; `rsp_id` still updates to the new owner and a response is still issued.
- All other opcodes: `rsp_result` = `alu_result`, flags = ALU flags, both sampled at the EXEC→RESP edge. The block applies no width or sign manipulation; values pass through bit-exact.
- `rsp_*` outputs stay stable while `rsp_valid` is high and not yet accepted.

## Timing
- Reset (async assert, synchronous deassert expected upstream):
  - state = IDLE, `ptr` = 0.
  - `gnt`, `alu_sel`, `alu_a`, `alu_b`, `rsp_valid`, `rsp_id`, `rsp_result`, all `rsp_*` flags and `busy` = 0.
- Acceptance edge T (in IDLE with `req & gnt`): `alu_*` valid after T, `busy` = 1 after T.
- Response: `rsp_valid` = 1 after edge T+1. Latency is 2 cycles from acceptance to response.
- Minimum turnaround is 3 cycles per operation, with `rsp_ready` tied high: IDLE, EXEC, RESP.
- Back-pressure: with `rsp_ready` = 0, the FSM stays in RESP indefinitely and no new grant is issued.
- Reset mid-operation, in EXEC or RESP: the in-flight operation is discarded, no response is produced, and `ptr` returns to 0.

## Configuration
- `ALU_ARB_FIXED_PRI_EN`:
  - Defined: fixed priority, lowest index wins; `ptr` is neither implemented nor updated.
  - Undefined (default): round-robin as described in Operation.

## Test plan
- Reset: hold `rst_n`=0 with all `req`=1 → `gnt`=0, `rsp_valid`=0 and all outputs 0. Release reset → `gnt`=4'b0001 in the first IDLE cycle.
- Single op: requester 2, `sel`=4'b0100, a=12'd5, b=12'd7, `rsp_ready`=1 → `gnt`=4'b0100, and 2 cycles later `rsp_valid`=1, `rsp_id`=2, `rsp_result`=12'd12, `altb`=1.
- Round-robin: `req`=4'b1111 held, `rsp_ready`=1 → grant order 0,1,2,3,0, one grant every 3 cycles. With `ALU_ARB_FIXED_PRI_EN` defined → requester 0 every time.
- Back-pressure: `rsp_ready`=0 for 10 cycles with `req`=4'b0011 → `rsp_*` stable, `gnt`=0 throughout. Raise `rsp_ready` → next grant goes to requester 1.
- No-op: an op with `sel`=4'b0101, a=12'd9, b=12'd3 gives `rsp_result`=12'd6 and `agrtb`=1. A following op with `sel`=4'b1111, a=b=0 → `rsp_result`=12'd6, `agrtb`=1, `aeqb`=0.
- Mid-op reset: assert `rst_n`=0 in EXEC → `rsp_valid` never rises for that op; after release the FSM is in IDLE with `ptr`=0.
